mod_arbiter: RTL and testbench

//   Round-robin scheduler sharing one iterative mod unit (a mod b, start/done) among NUM_REQ

---
 rtl/mod_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mod_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_arbiter.sv
// Round-robin scheduler sharing one iterative a-mod-b unit among NUM_REQ requesters.
// Grants one job at a time, bypasses divide-by-zero, and aborts hung jobs via a watchdog.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_req                level request per requester
//   i_req_a, i_req_b     packed operands, requester i at [i*WIDTH +: WIDTH]
//   o_gnt                one-hot pulse when the winner's operands are captured
//   o_rsp_valid          one-hot pulse qualifying o_rsp_result / o_rsp_err
//   o_rsp_result         result (held between pulses)
//   o_rsp_err            00 ok, 01 divisor zero, 10 timeout (held between pulses)
//   o_busy               high whenever the scheduler is not idle
//   o_mod_start          start pulse to the mod unit
//   o_mod_a, o_mod_b     operands to the mod unit, stable from start to done
//   i_mod_done           unit completion pulse, honoured only while waiting
//   i_mod_result         unit result, valid with i_mod_done

module mod_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]         o_rsp_result,
    output logic [1:0]               o_rsp_err,
    output logic                     o_busy,
    output logic                     o_mod_start,
    output logic [WIDTH-1:0]         o_mod_a,
    output logic [WIDTH-1:0]         o_mod_b,
    input  logic                     i_mod_done,
    input  logic [WIDTH-1:0]         i_mod_result
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WDW-1:0]    r_wd;
    logic [WIDTH-1:0]  r_rsp_result;
    logic [1:0]        r_rsp_err;

    logic              w_found;
    logic [IDXW-1:0]   w_win;
    logic [WIDTH-1:0]  w_win_a;
    logic [WIDTH-1:0]  w_win_b;
    logic              w_wd_exp;

    // Operands never exceed 2*NUM_REQ-1, so one conditional subtract wraps them.
    function automatic logic [IDXW-1:0] f_wrap(input int v);
        int t;
        t = (v >= NUM_REQ) ? v - NUM_REQ : v;
        return t[IDXW-1:0];
    endfunction

    // Scan from the round-robin pointer upward; first set request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    assign w_win_a  = i_req_a[w_win*WIDTH +: WIDTH];
    assign w_win_b  = i_req_b[w_win*WIDTH +: WIDTH];

    // Watchdog counts WAIT cycles from 0, so this bounds WAIT to TIMEOUT cycles.
    assign w_wd_exp = (r_wd == WDW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_gnt       = '0;
        o_rsp_valid = '0;
        o_mod_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_gnt[r_idx] = 1'b1;
                if (r_b != '0) begin
                    o_mod_start = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (i_mod_done || w_wd_exp) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid[r_idx] = 1'b1;
                w_state_nxt        = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr     <= '0;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_wd         <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 2'b00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx <= w_win;
                        r_a   <= w_win_a;
                        r_b   <= w_win_b;
                    end
                end
                S_ISSUE: begin
                    r_wd <= '0;
                    if (r_b == '0) begin
                        r_rsp_result <= r_a;
                        r_rsp_err    <= 2'b01;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (i_mod_done) begin
                        r_rsp_result <= i_mod_result;
                        r_rsp_err    <= 2'b00;
                    end else if (w_wd_exp) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 2'b10;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= f_wrap(int'(r_idx) + 1);
                end
                default: begin
                    r_wd <= '0;
                end
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_mod_a      = r_a;
    assign o_mod_b      = r_b;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter with a behavioural mod unit of programmable latency.

module tb_mod_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic [1:0]     rsp_err;
    logic           busy;
    logic           mod_start;
    logic [W-1:0]   mod_a;
    logic [W-1:0]   mod_b;
    logic           mod_done;
    logic [W-1:0]   mod_result;

    int             unit_lat = 3;
    logic           hang = 1'b0;
    logic           stray = 1'b0;
    int             cnt = 0;
    int             n_start = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    logic [3:0]     exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0]    exp_r [5] = '{32'd3, 32'd1, 32'd2, 32'd4, 32'd3};

    always #5 clk = ~clk;

    mod_arbiter #(
        .NUM_REQ(N),
        .WIDTH(W),
        .TIMEOUT(64)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_req(req),
        .i_req_a(req_a),
        .i_req_b(req_b),
        .o_gnt(gnt),
        .o_rsp_valid(rsp_valid),
        .o_rsp_result(rsp_result),
        .o_rsp_err(rsp_err),
        .o_busy(busy),
        .o_mod_start(mod_start),
        .o_mod_a(mod_a),
        .o_mod_b(mod_b),
        .i_mod_done(mod_done),
        .i_mod_result(mod_result)
    );

    // Behavioural unit: done arrives unit_lat cycles after the start cycle.
    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else if (mod_start) cnt <= unit_lat;
        else if (cnt != 0) cnt <= cnt - 1;
        if (!reset && mod_start) n_start <= n_start + 1;
    end

    assign mod_done   = ((cnt == 1) && !hang) || stray;
    assign mod_result = stray ? 32'd77 :
                        (mod_b != 0) ? mod_a % mod_b : 32'd0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_job(input int idx, input logic [31:0] a,
                           input logic [31:0] b, input int bound,
                           output int t_gnt, output int t_rsp,
                           output logic [3:0] gv, output logic [3:0] rv);
        t_gnt = -1;
        t_rsp = -1;
        gv    = '0;
        rv    = '0;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req[idx] = 1'b1;
        for (int c = 1; c <= bound; c++) begin
            tick();
            if (gnt != 0 && t_gnt < 0) begin
                t_gnt = c;
                gv = gnt;
                req[idx] = 1'b0;
            end
            if (rsp_valid != 0) begin
                t_rsp = c;
                rv = rsp_valid;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int         tg;
        int         tr;
        int         s0;
        logic [3:0] gv;
        logic [3:0] rv;
        logic [3:0] acc;

        repeat (3) tick();
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start", mod_start, 0);
        check("rst_mod_a", mod_a, 0);
        check("rst_result", rsp_result, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b0;
        tick();

        // single job
        unit_lat = 3;
        run_job(0, 32'd100, 32'd7, 20, tg, tr, gv, rv);
        check("t1_gnt_t", tg, 1);
        check("t1_gnt", gv, 4'b0001);
        check("t1_rsp_t", tr, 5);
        check("t1_rsp", rv, 4'b0001);
        check("t1_result", rsp_result, 2);
        check("t1_err", rsp_err, 0);
        tick();
        check("t1_hold_result", rsp_result, 2);
        check("t1_idle_busy", busy, 0);

        // fairness
        reset = 1'b1;
        tick();
        reset = 1'b0;
        unit_lat = 2;
        req_a = {32'd44, 32'd32, 32'd21, 32'd13};
        req_b = {4{32'd5}};
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            gv = '0;
            rv = '0;
            for (int c = 0; c < 20 && gv == 0; c++) begin
                tick();
                gv = gnt;
            end
            for (int c = 0; c < 20 && rv == 0; c++) begin
                tick();
                rv = rsp_valid;
            end
            check($sformatf("t2_gnt%0d", j), gv, exp_g[j]);
            check($sformatf("t2_rsp%0d", j), rv, exp_g[j]);
            check($sformatf("t2_res%0d", j), rsp_result, exp_r[j]);
        end
        req = '0;
        tick();

        // divide by zero
        s0 = n_start;
        run_job(2, 32'd55, 32'd0, 20, tg, tr, gv, rv);
        check("t3_gnt", gv, 4'b0100);
        check("t3_rsp_t", tr, 2);
        check("t3_rsp", rv, 4'b0100);
        check("t3_result", rsp_result, 55);
        check("t3_err", rsp_err, 1);
        check("t3_no_start", n_start, s0);
        tick();

        // timeout, then a normal job
        hang = 1'b1;
        run_job(1, 32'd9, 32'd4, 100, tg, tr, gv, rv);
        check("t4_rsp_t", tr, 66);
        check("t4_rsp", rv, 4'b0010);
        check("t4_result", rsp_result, 0);
        check("t4_err", rsp_err, 2);
        hang = 1'b0;
        unit_lat = 3;
        tick();
        run_job(1, 32'd9, 32'd4, 20, tg, tr, gv, rv);
        check("t4b_rsp_t", tr, 5);
        check("t4b_result", rsp_result, 1);
        check("t4b_err", rsp_err, 0);
        tick();

        // reset while waiting
        unit_lat = 10;
        req_a[0 +: W] = 32'd50;
        req_b[0 +: W] = 32'd6;
        req[0] = 1'b1;
        tick();
        check("t5_gnt", gnt, 4'b0001);
        req[0] = 1'b0;
        tick();
        check("t5_wait_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", busy, 0);
        acc = '0;
        for (int c = 0; c < 15; c++) begin
            acc = acc | rsp_valid;
            tick();
        end
        check("t5_no_rsp", acc, 0);
        unit_lat = 3;
        req_a[3*W +: W] = 32'd17;
        req_b[3*W +: W] = 32'd5;
        req = 4'b1001;
        tick();
        check("t5_ptr0_gnt", gnt, 4'b0001);
        req = '0;
        rv = '0;
        for (int c = 0; c < 20 && rv == 0; c++) begin
            tick();
            rv = rsp_valid;
        end
        check("t5_ptr0_result", rsp_result, 2);
        tick();
        run_job(3, 32'd17, 32'd5, 20, tg, tr, gv, rv);
        check("t5_req3_gnt", gv, 4'b1000);
        check("t5_req3_result", rsp_result, 2);
        tick();

        // stray done in idle, then done coinciding with timeout
        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("t6_stray_rsp", rsp_valid, 0);
        check("t6_stray_busy", busy, 0);
        tick();
        check("t6_stray_hold", rsp_result, 2);
        unit_lat = 64;
        run_job(2, 32'd70, 32'd8, 100, tg, tr, gv, rv);
        check("t6_coin_rsp_t", tr, 66);
        check("t6_coin_result", rsp_result, 6);
        check("t6_coin_err", rsp_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
